// File: rtl/sseg_pkg.sv
// Shared types and constants for the scrolling 7-seg message sequencer.
// Contents: blank nibble code, window width, FSM state enum, nibble type.
package sseg_pkg;

    localparam logic [3:0]  NIB_BLANK  = 4'hB;
    localparam int unsigned WIN_DIGITS = 4;

    typedef logic [3:0] nib_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        SHOW  = 2'd3
    } state_e;

endpackage

// File: rtl/sseg_tick_gen.sv
// Free-running prescaler for the scroll step.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (message commit)
//   tick       : high while the counter is all-ones
//   msb        : counter MSB (blink phase)
module sseg_tick_gen #(
    parameter int unsigned STEP_DIV_BITS = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick,
    output logic msb
);

    logic [STEP_DIV_BITS-1:0] cnt;

    // Counter wraps naturally; only a commit restarts the phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + STEP_DIV_BITS'(1);
        end
    end

    assign tick = &cnt;
    assign msb  = cnt[STEP_DIV_BITS-1];

endmodule

// File: rtl/sseg_scroll_ctrl.sv
// Message sequencer feeding the 4-digit time-multiplexed 7-seg driver.
// Buffers a nibble message from a valid/ready stream and marquee-scrolls a
// 4-digit window over it (message followed by four blanks, wrapping).
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   blink_en            : only with SSEG_SCROLL_BLINK_EN; blank window on alternate half-periods
//   wr_valid/wr_ready   : message beat handshake (ready is always high)
//   wr_nib, wr_last     : message nibble and end-of-message marker
//   scroll_en           : advance window on tick when high
//   busy                : high while a message is being received (LOAD/DRAIN)
//   msg_len             : committed message length
//   digits              : {d3,d2,d1,d0}, d3 leftmost
// Optional feature macro: SSEG_SCROLL_BLINK_EN
module sseg_scroll_ctrl
    import sseg_pkg::*;
#(
    parameter int unsigned MSG_DEPTH     = 16,
    parameter int unsigned STEP_DIV_BITS = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef SSEG_SCROLL_BLINK_EN
    input  logic                       blink_en,
`endif
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [3:0]                 wr_nib,
    input  logic                       wr_last,
    input  logic                       scroll_en,
    output logic                       busy,
    output logic [$clog2(MSG_DEPTH):0] msg_len,
    output logic [15:0]                digits
);

    localparam int unsigned AW = $clog2(MSG_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned IW = PW + 1;
    localparam logic [15:0] BLANK_WIN = {WIN_DIGITS{NIB_BLANK}};

    state_e          state, state_d;
    logic [PW-1:0]   wptr, wptr_d;
    logic [PW-1:0]   len_d;
    logic [PW-1:0]   pos, pos_d;
    logic            commit;
    logic            buf_we;
    logic [AW-1:0]   buf_idx;
    logic            tick;
    logic            tick_msb;
    logic [15:0]     win_c;
    logic [15:0]     digits_d;
    logic [IW-1:0]   span;
    logic [IW-1:0]   idx;
    nib_t            nib;
    nib_t            msg_buf [MSG_DEPTH];

    assign wr_ready = 1'b1;
    assign busy     = (state == LOAD) || (state == DRAIN);

    sseg_tick_gen #(
        .STEP_DIV_BITS(STEP_DIV_BITS)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (commit),
        .tick (tick),
        .msb  (tick_msb)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state, buffer write and position control
    always_comb begin
        state_d = state;
        wptr_d  = wptr;
        len_d   = msg_len;
        pos_d   = pos;
        commit  = 1'b0;
        buf_we  = 1'b0;
        buf_idx = wptr[AW-1:0];
        case (state)
            IDLE, SHOW: begin
                // A new message pre-empts any scroll step in the same cycle.
                if (wr_valid) begin
                    buf_we  = 1'b1;
                    buf_idx = '0;
                    wptr_d  = PW'(1);
                    if (wr_last) begin
                        commit = 1'b1;
                        len_d  = PW'(1);
                    end else begin
                        state_d = LOAD;
                    end
                end else if (state == SHOW && tick && scroll_en &&
                             msg_len > PW'(WIN_DIGITS)) begin
                    pos_d = (pos == msg_len + PW'(3)) ? '0 : pos + PW'(1);
                end
            end
            LOAD: begin
                if (wr_valid) begin
                    buf_we = 1'b1;
                    wptr_d = wptr + PW'(1);
                    if (wr_last) begin
                        commit = 1'b1;
                        len_d  = wptr + PW'(1);
                    end else if (wptr == PW'(MSG_DEPTH - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (wr_valid && wr_last) begin
                    commit = 1'b1;
                    len_d  = PW'(MSG_DEPTH);
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            state_d = SHOW;
            pos_d   = '0;
        end
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            msg_len <= '0;
            pos     <= '0;
            digits  <= BLANK_WIN;
        end else begin
            wptr    <= wptr_d;
            msg_len <= len_d;
            pos     <= pos_d;
            digits  <= digits_d;
        end
    end

    // Message buffer, no reset needed
    always_ff @(posedge clk) begin
        if (buf_we) begin
            msg_buf[buf_idx] <= wr_nib;
        end
    end

    // Window over V = msg followed by four blanks; pos <= L+3 so one subtract wraps
    always_comb begin
        win_c = BLANK_WIN;
        span  = IW'(msg_len) + IW'(WIN_DIGITS);
        idx   = '0;
        nib   = NIB_BLANK;
        for (int k = 0; k < int'(WIN_DIGITS); k++) begin
            idx = IW'(pos) + IW'(k);
            if (idx >= span) begin
                idx = idx - span;
            end
            if (idx < IW'(msg_len)) begin
                nib = msg_buf[idx[AW-1:0]];
            end else begin
                nib = NIB_BLANK;
            end
            win_c[4*(int'(WIN_DIGITS)-1-k) +: 4] = nib;
        end
    end

    // Output select
    always_comb begin
        digits_d = BLANK_WIN;
        if (state == SHOW) begin
            digits_d = win_c;
        end
`ifdef SSEG_SCROLL_BLINK_EN
        if (state == SHOW && blink_en && tick_msb) begin
            digits_d = BLANK_WIN;
        end
`endif
    end

`ifndef SSEG_SCROLL_BLINK_EN
    logic unused_msb;
    assign unused_msb = tick_msb;
`endif

endmodule
